// File: rtl/joy_db15_tx.sv
// joy_db15_tx
//
// Responder side of the DB15 splitter serial joystick link. It emulates the
// splitter's parallel-in/serial-out shift chain, so that a host core can read
// two 12-button joysticks over JOY_CLK / JOY_LOAD / JOY_DATA. It is used by the
// loopback harness and on boards that act as the splitter toward another host.
//
// All logic runs on the system clock. The host's clock and load lines are
// asynchronous, so they are synchronised and edge-detected before use.
//
// Parameters
//   LEAD_BITS   : filler bits (driven 1) presented before frame bit 0
//   SYNC_STAGES : synchroniser depth for joy_clk / joy_load (2..3)
//
// Ports
//   clk         in   system clock (48-50 MHz)
//   rst_n       in   asynchronous active-low reset
//   joy_clk     in   host shift clock, asynchronous, rising edge shifts
//   joy_load    in   host load strobe, asynchronous, active-low
//   joy_data    out  serial data to host, active-low buttons (0 = pressed)
//   joystick1   in   P1 buttons, active-high, bits 11:0 used
//   joystick2   in   P2 buttons, active-high, bits 11:0 used
//   load_strobe out  one-clk pulse per falling edge of synchronised joy_load
//   frame_done  out  one-clk pulse when the last frame bit has been shifted past

module joy_db15_tx #(
  parameter int LEAD_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        joy_clk,
  input  logic        joy_load,
  output logic        joy_data,
  input  logic [15:0] joystick1,
  input  logic [15:0] joystick2,
  output logic        load_strobe,
  output logic        frame_done
);

  localparam int SR_W  = LEAD_BITS + 24;
  localparam int IDX_W = $clog2(SR_W + 1);
  localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(SR_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SR_W - 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] load_sync;
  logic                   clk_d;
  logic                   load_d;
  logic                   clk_rise;
  logic                   load_low;
  logic                   load_fall;
  logic [SR_W-1:0]        load_word;
  logic [SR_W-1:0]        shift_reg;
  logic [IDX_W-1:0]       bit_idx;
  logic                   unused_bits;

  // Bits 15:12 of each joystick word carry nothing on this link.
  assign unused_bits = ^{joystick1[15:12], joystick2[15:12]};

  // Synchronisers plus one delay flop for edge detection. The clock chain
  // resets low and the load chain resets high (idle levels), so releasing
  // reset never manufactures an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= '0;
      load_sync <= '1;
      clk_d     <= 1'b0;
      load_d    <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], joy_clk};
      load_sync <= {load_sync[SYNC_STAGES-2:0], joy_load};
      clk_d     <= clk_sync[SYNC_STAGES-1];
      load_d    <= load_sync[SYNC_STAGES-1];
    end
  end

  assign clk_rise  = clk_sync[SYNC_STAGES-1] & ~clk_d;
  assign load_low  = ~load_sync[SYNC_STAGES-1];
  assign load_fall = ~load_sync[SYNC_STAGES-1] & load_d;

  // Parallel load image. The MSB end is the head of the chain: filler first,
  // then wire position 0 down to wire position 23 at bit 0. Buttons are
  // inverted because the wire is active-low.
  always_comb begin
    load_word       = '1;
    load_word[23:0] = ~{joystick1[7],  joystick1[6],  joystick1[5],  joystick1[4],
                        joystick1[0],  joystick1[1],  joystick1[2],  joystick1[3],
                        joystick2[0],  joystick2[1],  joystick2[2],  joystick2[3],
                        joystick1[9],  joystick1[8],  joystick1[11], joystick1[10],
                        joystick2[9],  joystick2[8],  joystick2[11], joystick2[10],
                        joystick2[7],  joystick2[6],  joystick2[5],  joystick2[4]};
  end

  // Shift chain. Load is transparent while held low and wins over a clock
  // edge in the same cycle. Shifting pulls 1s into the tail, so clocking past
  // the end keeps presenting "released". The index saturates, which makes
  // frame_done fire only on the step into the final count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg   <= '1;
      bit_idx     <= '0;
      load_strobe <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      load_strobe <= load_fall;
      frame_done  <= 1'b0;
      if (load_low) begin
        shift_reg <= load_word;
        bit_idx   <= '0;
      end else if (clk_rise) begin
        shift_reg <= {shift_reg[SR_W-2:0], 1'b1};
        if (bit_idx != IDX_MAX) begin
          bit_idx    <= bit_idx + 1'b1;
          frame_done <= (bit_idx == IDX_LAST);
        end
      end
    end
  end

  assign joy_data = shift_reg[SR_W-1];

endmodule
